// File: rtl/ddr4_col_cmd_gate_pkg.sv
// Shared DDR4 model constants and helpers for the column-command gate.
// - BL8_CLKS : clocks occupied by one BL8 data burst on the DQ bus
// - MIN_CCD  : floor applied to the column-to-column spacing settings
// - MIN_LAT  : smallest legal CL/CWL
// - eff_ccd(): spacing setting with the MIN_CCD floor applied
package ddr4_col_cmd_gate_pkg;

  localparam int BL8_CLKS = 4;
  localparam int MIN_CCD  = 4;
  localparam int MIN_LAT  = 9;

  // A burst occupies BL8_CLKS clocks, so column commands can never be closer
  // than that even if the speed-bin table returns something smaller.
  function automatic logic [3:0] eff_ccd(input logic [3:0] x);
    return (x < 4'(MIN_CCD)) ? 4'(MIN_CCD) : x;
  endfunction

endpackage

// File: rtl/ddr4_col_cmd_gate_if.sv
// Column-command handshake bundle.
// - cmd_valid : command presented by the source
// - cmd_ready : command may issue this cycle (driven by the gate)
// - cmd_wr    : 1 = WR, 0 = RD
// - cmd_bg    : target bank group
// master = command source, slave = timing gate.
interface ddr4_col_cmd_gate_if #(
  parameter int NUM_BG = 4
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_wr;
  logic [$clog2(NUM_BG)-1:0] cmd_bg;

  modport master (output cmd_valid, output cmd_wr, output cmd_bg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_wr, input cmd_bg, output cmd_ready);
endinterface

// File: rtl/ddr4_lat_window.sv
// Latency-delayed data-window generator for one direction (RD or WR).
// A command issue schedules a bit at position lat-1 of a shift vector that
// moves toward bit 0 every clock; when the bit reaches 0 the window opens and
// a tail counter keeps it open for the rest of the BL8 burst.
// - clk, rst : clock, synchronous active-high reset
// - set      : command issued this cycle
// - lat      : latency in clocks for the command being issued (1..MAX_LAT)
// - en_out   : data window, high for BL8_CLKS clocks starting lat clocks after set
// - active   : a window is scheduled or currently open
module ddr4_lat_window
  import ddr4_col_cmd_gate_pkg::*;
#(
  parameter int MAX_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic [5:0] lat,
  output logic       en_out,
  output logic       active
);

  logic [MAX_LAT-1:0] pend_reg;
  logic [MAX_LAT-1:0] set_vec;
  logic [1:0]         tail_reg;

  // One-hot insert position; an out-of-range lat simply schedules nothing.
  for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_set
    assign set_vec[gi] = set && (lat == 6'(gi + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
      tail_reg <= '0;
    end else begin
      pend_reg <= {1'b0, pend_reg[MAX_LAT-1:1]} | set_vec;
      // Burst spacing is at least BL8_CLKS, so a reload while the tail is
      // still counting only ever happens for an abutting burst.
      if (pend_reg[0]) begin
        tail_reg <= 2'(BL8_CLKS - 1);
      end else if (tail_reg != 2'd0) begin
        tail_reg <= tail_reg - 2'd1;
      end
    end
  end

  assign en_out = pend_reg[0] || (tail_reg != 2'd0);
  assign active = (|pend_reg) || (tail_reg != 2'd0);

endmodule

// File: rtl/ddr4_col_cmd_gate.sv
// Column-command timing gate. Enforces tCCD_L/tCCD_S between column commands
// and tWTR_L/tWTR_S from write-burst end to a following read, using a
// valid/ready handshake, and emits RD/WR data-enable windows at CL/CWL.
// - clk, rst            : clock, synchronous active-high reset
// - cmd                 : command handshake (slave side)
// - cfg_cl / cfg_cwl    : read / write latency in clocks
// - cfg_ccd_l/cfg_ccd_s : same-/different-bank-group column spacing
// - cfg_wtr_l/cfg_wtr_s : write-to-read delay after write burst end
// - rd_en / wr_en       : BL8 data windows for the DQ driver/checker
// - cfg_err             : registered configuration-illegal flag
// - busy                : any spacing counter, pending bit or window active
module ddr4_col_cmd_gate
  import ddr4_col_cmd_gate_pkg::*;
#(
  parameter int NUM_BG  = 4,
  parameter int MAX_LAT = 32,
  parameter int CNT_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  ddr4_col_cmd_gate_if.slave         cmd,
  input  logic [5:0]                 cfg_cl,
  input  logic [5:0]                 cfg_cwl,
  input  logic [3:0]                 cfg_ccd_l,
  input  logic [3:0]                 cfg_ccd_s,
  input  logic [3:0]                 cfg_wtr_l,
  input  logic [3:0]                 cfg_wtr_s,
  output logic                       rd_en,
  output logic                       wr_en,
  output logic                       cfg_err,
  output logic                       busy
);

  localparam int         BG_W   = $clog2(NUM_BG);
  localparam logic [5:0] LAT_LO = 6'(MIN_LAT);
  localparam logic [5:0] LAT_HI = 6'(MAX_LAT);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] x);
    return (x == '0) ? '0 : x - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] ccd_bg_reg [NUM_BG];
  logic [CNT_W-1:0] wtr_bg_reg [NUM_BG];
  logic [CNT_W-1:0] ccd_any_reg;
  logic [CNT_W-1:0] wtr_any_reg;
  logic             cfg_err_reg;

  logic             cfg_bad;
  logic             ready;
  logic             issue, issue_rd, issue_wr;
  logic [CNT_W-1:0] ccd_l_load, ccd_s_load, wtr_l_load, wtr_s_load;
  logic [NUM_BG-1:0] bg_busy;
  logic             rd_active, wr_active;

  assign cfg_bad = (cfg_cl  < LAT_LO) || (cfg_cl  > LAT_HI) ||
                   (cfg_cwl < LAT_LO) || (cfg_cwl > LAT_HI) ||
                   (cfg_ccd_l < cfg_ccd_s);

  // Counters hold "clocks still to wait after this one", hence the -1:
  // a counter loaded at issue edge t reaches zero in time for edge t+N.
  assign ccd_l_load = CNT_W'(eff_ccd(cfg_ccd_l)) - CNT_W'(1);
  assign ccd_s_load = CNT_W'(eff_ccd(cfg_ccd_s)) - CNT_W'(1);
  // tWTR is measured from the end of the write burst, i.e. CWL+BL8 after WR.
  assign wtr_l_load = CNT_W'(cfg_cwl) + CNT_W'(BL8_CLKS) + CNT_W'(cfg_wtr_l) - CNT_W'(1);
  assign wtr_s_load = CNT_W'(cfg_cwl) + CNT_W'(BL8_CLKS) + CNT_W'(cfg_wtr_s) - CNT_W'(1);

  // Ready depends only on registered state and the command fields, never on
  // cmd_valid. Reads additionally wait out tWTR; read-to-write turnaround is
  // left to the command source.
  assign ready = !rst && !cfg_err_reg &&
                 (ccd_bg_reg[cmd.cmd_bg] == '0) && (ccd_any_reg == '0) &&
                 (cmd.cmd_wr || ((wtr_bg_reg[cmd.cmd_bg] == '0) && (wtr_any_reg == '0)));

  assign cmd.cmd_ready = ready;
  assign issue    = cmd.cmd_valid && ready;
  assign issue_rd = issue && !cmd.cmd_wr;
  assign issue_wr = issue && cmd.cmd_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BG; i++) begin
        ccd_bg_reg[i] <= '0;
        wtr_bg_reg[i] <= '0;
      end
      ccd_any_reg <= '0;
      wtr_any_reg <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_bad;
      ccd_any_reg <= issue    ? ccd_s_load : sat_dec(ccd_any_reg);
      wtr_any_reg <= issue_wr ? wtr_s_load : sat_dec(wtr_any_reg);
      for (int i = 0; i < NUM_BG; i++) begin
        if (issue && (cmd.cmd_bg == BG_W'(i))) begin
          ccd_bg_reg[i] <= ccd_l_load;
        end else begin
          ccd_bg_reg[i] <= sat_dec(ccd_bg_reg[i]);
        end
        if (issue_wr && (cmd.cmd_bg == BG_W'(i))) begin
          wtr_bg_reg[i] <= wtr_l_load;
        end else begin
          wtr_bg_reg[i] <= sat_dec(wtr_bg_reg[i]);
        end
      end
    end
  end

  ddr4_lat_window #(.MAX_LAT(MAX_LAT)) u_rd_window (
    .clk    (clk),
    .rst    (rst),
    .set    (issue_rd),
    .lat    (cfg_cl),
    .en_out (rd_en),
    .active (rd_active)
  );

  ddr4_lat_window #(.MAX_LAT(MAX_LAT)) u_wr_window (
    .clk    (clk),
    .rst    (rst),
    .set    (issue_wr),
    .lat    (cfg_cwl),
    .en_out (wr_en),
    .active (wr_active)
  );

  for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_bg_busy
    assign bg_busy[gi] = (ccd_bg_reg[gi] != '0) || (wtr_bg_reg[gi] != '0);
  end

  assign busy    = (|bg_busy) || (ccd_any_reg != '0) || (wtr_any_reg != '0) ||
                   rd_active || wr_active;
  assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_ddr4_col_cmd_gate.sv
// Directed bench for ddr4_col_cmd_gate. Issue spacing is checked directly;
// data windows are checked every cycle against a scoreboard of windows pushed
// when a command issues and retired as the windows pass.
module tb_ddr4_col_cmd_gate;

  logic       clk;
  logic       rst;
  logic [5:0] cfg_cl, cfg_cwl;
  logic [3:0] cfg_ccd_l, cfg_ccd_s, cfg_wtr_l, cfg_wtr_s;
  logic       rd_en, wr_en, cfg_err, busy;

  ddr4_col_cmd_gate_if #(.NUM_BG(4)) cmd_if ();

  ddr4_col_cmd_gate #(.NUM_BG(4), .MAX_LAT(32), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .cfg_cl    (cfg_cl),
    .cfg_cwl   (cfg_cwl),
    .cfg_ccd_l (cfg_ccd_l),
    .cfg_ccd_s (cfg_ccd_s),
    .cfg_wtr_l (cfg_wtr_l),
    .cfg_wtr_s (cfg_wtr_s),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int chks = 0;
  int cyc  = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int first;
    int last;
  } win_t;
  win_t rd_q[$];
  win_t wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at the falling edge, outputs reflect the state that the next
  // rising edge (slot = cyc+1) sees, and inputs are those that edge samples.
  int   m_slot;
  logic exp_rd, exp_wr;
  always @(negedge clk) begin
    if (mon_en) begin
      m_slot = cyc + 1;
      while (rd_q.size() > 0 && rd_q[0].last < m_slot) rd_q.delete(0);
      while (wr_q.size() > 0 && wr_q[0].last < m_slot) wr_q.delete(0);
      exp_rd = (rd_q.size() > 0) && (rd_q[0].first <= m_slot);
      exp_wr = (wr_q.size() > 0) && (wr_q[0].first <= m_slot);
      check("rd_en_window", rd_en, exp_rd);
      check("wr_en_window", wr_en, exp_wr);
      if (rst) begin
        rd_q.delete();
        wr_q.delete();
      end else if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        $display("issue slot=%0d wr=%0d bg=%0d", m_slot, cmd_if.cmd_wr, cmd_if.cmd_bg);
        if (cmd_if.cmd_wr) wr_q.push_back('{m_slot + int'(cfg_cwl), m_slot + int'(cfg_cwl) + 3});
        else               rd_q.push_back('{m_slot + int'(cfg_cl),  m_slot + int'(cfg_cl)  + 3});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present a command and hold it until it issues; returns the issue slot,
  // or -1 if it never issued within the budget.
  task automatic send(input logic wr, input logic [1:0] bg, output int slot);
    int n;
    n = 0;
    slot = -1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_wr    = wr;
    cmd_if.cmd_bg    = bg;
    while (slot < 0 && n < 200) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) slot = cyc + 1;
      @(posedge clk);
      #2;
      n++;
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_wr    = 1'b0;
    cmd_if.cmd_bg    = 2'd0;
  endtask

  task automatic count_rd(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (rd_en === 1'b1) hits++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, s3, hits;
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_wr    = 1'b0;
    cmd_if.cmd_bg    = 2'd0;
    cfg_cl = 6'd16; cfg_cwl = 6'd12;
    cfg_ccd_l = 4'd6; cfg_ccd_s = 4'd4;
    cfg_wtr_l = 4'd9; cfg_wtr_s = 3'd3;

    // Reset state
    step(3);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_if.cmd_ready, 1'b1);
    step(1);
    check("cfg_err_after_rst", cfg_err, 1'b0);

    // Single read: window checked by the scoreboard, busy while in flight
    send(1'b0, 2'd0, s0);
    check("rd_issue_busy", busy, 1'b1);
    step(60);
    check("rd_idle_busy", busy, 1'b0);

    // Same-BG and other-BG column spacing
    send(1'b0, 2'd0, s0);
    send(1'b0, 2'd0, s1);
    check("ccd_l_gap", s1 - s0, 6);
    step(60);
    send(1'b0, 2'd0, s0);
    send(1'b0, 2'd1, s1);
    check("ccd_s_gap", s1 - s0, 4);
    step(60);

    // Write-to-read spacing
    send(1'b1, 2'd2, s0);
    send(1'b0, 2'd2, s1);
    check("wtr_l_gap", s1 - s0, 25);
    step(60);
    send(1'b1, 2'd2, s0);
    send(1'b0, 2'd3, s1);
    check("wtr_s_gap", s1 - s0, 19);
    step(60);
    check("wr_idle_busy", busy, 1'b0);

    // Back-to-back reads alternating BG: abutting windows
    cfg_ccd_l = 4'd5;
    send(1'b0, 2'd0, s0);
    send(1'b0, 2'd1, s1);
    send(1'b0, 2'd0, s2);
    send(1'b0, 2'd1, s3);
    check("b2b_gap1", s1 - s0, 4);
    check("b2b_gap2", s2 - s0, 8);
    check("b2b_gap3", s3 - s0, 12);
    count_rd(40, hits);
    check("b2b_rd_len", hits, 16);
    step(30);
    cfg_ccd_l = 4'd6;

    // Configuration legality
    cfg_cl = 6'd8;
    step(1);
    check("cl8_err", cfg_err, 1'b1);
    check("cl8_ready", cmd_if.cmd_ready, 1'b0);
    cfg_cl = 6'd9;
    #1;
    check("cl9_ready_lag", cmd_if.cmd_ready, 1'b0);
    step(1);
    check("cl9_err", cfg_err, 1'b0);
    check("cl9_ready", cmd_if.cmd_ready, 1'b1);
    cfg_cwl = 6'd33;
    step(1);
    check("cwl33_err", cfg_err, 1'b1);
    cfg_cwl = 6'd32;
    step(1);
    check("cwl32_err", cfg_err, 1'b0);
    cfg_ccd_l = 4'd3;
    step(1);
    check("ccd_order_err", cfg_err, 1'b1);
    cfg_ccd_l = 4'd6; cfg_cwl = 6'd12; cfg_cl = 6'd16;
    step(1);
    check("cfg_restored", cfg_err, 1'b0);

    // Reset mid-operation cancels the scheduled window
    send(1'b0, 2'd0, s0);
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    count_rd(30, hits);
    check("rst_cancel_rd", hits, 0);
    check("rst_cancel_busy", busy, 1'b0);
    check("rst_cancel_ready", cmd_if.cmd_ready, 1'b1);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
